// File: rtl/led_pattern_gen_pkg.sv
// Shared types and helpers for the LED pattern generator.
//   mode_e       : 3-bit pattern select (codes 6-7 are unused and act as OFF)
//   MODE_W       : width of mode_e
//   MAX_LEDS     : widest LED bank the helper function can describe
//   init_pattern : pattern a mode starts from, for a bank of n LEDs
package led_pattern_pkg;

  localparam int MODE_W   = 3;
  localparam int MAX_LEDS = 64;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 3'd0,
    MODE_ON     = 3'd1,
    MODE_BLINK  = 3'd2,
    MODE_CHASE  = 3'd3,
    MODE_BOUNCE = 3'd4,
    MODE_COUNT  = 3'd5
  } mode_e;

  // Result is MAX_LEDS wide; the caller keeps the low n bits (n <= MAX_LEDS).
  function automatic logic [MAX_LEDS-1:0] init_pattern(input mode_e m, input int unsigned n);
    logic [MAX_LEDS-1:0] all_ones;
    logic [MAX_LEDS-1:0] lsb_only;
    all_ones = {MAX_LEDS{1'b1}} >> (MAX_LEDS - n);
    lsb_only = {{(MAX_LEDS-1){1'b0}}, 1'b1};
    case (m)
      MODE_ON:                 return all_ones;
      MODE_CHASE, MODE_BOUNCE: return lsb_only;
      default:                 return '0;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle of the LED pattern generator.
//   master : drives enable, mode, brightness; observes out, tick
//   slave  : the generator itself
interface led_pattern_gen_if
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS  = 4,
  parameter int PWM_WIDTH = 8
) ();

  logic                 enable;
  mode_e                mode;
  logic [PWM_WIDTH-1:0] brightness;
  logic [NUM_LEDS-1:0]  out;
  logic                 tick;

  modport master (output enable, output mode, output brightness, input out, input tick);
  modport slave  (input enable, input mode, input brightness, output out, output tick);

endinterface

// File: rtl/led_pattern_gen_tick_prescaler.sv
// Step-interval prescaler: counts 0..TICK_COUNT-1 while enabled.
//   clk, rst : clock, synchronous active-high reset
//   enable   : count when high, hold when low
//   clear    : force the count back to 0 (wins over enable, suppresses tick)
//   tick     : combinational strobe, high on the cycle the count wraps
module tick_prescaler #(
  parameter int          COUNT_WIDTH = 32,
  parameter int unsigned TICK_COUNT  = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [COUNT_WIDTH-1:0] TERM = COUNT_WIDTH'(TICK_COUNT - 1);

  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   at_term;

  assign at_term = (cnt_q == TERM);
  assign tick    = enable && !clear && at_term;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = at_term ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: steps one of six patterns every TICK_COUNT cycles
// and gates the result with a free-running PWM for global brightness.
//   clk, rst       : system clock, synchronous active-high reset
//   bus.enable     : run (1) / pause (0) the pattern; PWM always runs
//   bus.mode       : pattern select (mode_e)
//   bus.brightness : PWM duty, all ones = fully on
//   bus.out        : registered LED drive
//   bus.tick       : registered one-cycle pulse while a new pattern is held
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int          NUM_LEDS    = 4,
  parameter int          COUNT_WIDTH = 32,
  parameter int unsigned TICK_COUNT  = 25_000_000,
  parameter int          PWM_WIDTH   = 8
) (
  input logic             clk,
  input logic             rst,
  led_pattern_gen_if.slave bus
);

  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  mode_e                mode_q;
  logic [NUM_LEDS-1:0]  pattern_q, pattern_d;
  logic [0:0]           dir_q, dir_d;
  logic                 tick_q, tick_d;
  logic [PWM_WIDTH-1:0] pwm_cnt_q;
  logic [NUM_LEDS-1:0]  out_q;

  logic                 mode_chg;
  logic                 step;
  logic                 gate;
  logic [MAX_LEDS-1:0]  init_w;
  logic [NUM_LEDS-1:0]  shl, shr;

  assign mode_chg = (bus.mode != mode_q);
  assign init_w   = init_pattern(bus.mode, NUM_LEDS);
  assign shl      = pattern_q << 1;
  assign shr      = pattern_q >> 1;
  assign gate     = (bus.brightness == '1) || (pwm_cnt_q < bus.brightness);

  // A mode change clears the prescaler, which also masks a coincident step.
  tick_prescaler #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .TICK_COUNT  (TICK_COUNT)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (bus.enable),
    .clear  (mode_chg),
    .tick   (step)
  );

  always_comb begin
    pattern_d = pattern_q;
    dir_d     = dir_q;
    tick_d    = 1'b0;
    if (mode_chg) begin
      pattern_d = init_w[NUM_LEDS-1:0];
      dir_d     = DIR_UP;
    end else if (step) begin
      tick_d = 1'b1;
      case (mode_q)
        MODE_ON:    pattern_d = '1;
        MODE_BLINK: pattern_d = ~pattern_q;
        MODE_CHASE: pattern_d = shl | (pattern_q >> (NUM_LEDS - 1));
        MODE_BOUNCE: begin
          // Turn around as soon as an end bit is lit so ends are shown once.
          if (NUM_LEDS == 1) begin
            pattern_d = pattern_q;
          end else if (dir_q == DIR_UP) begin
            pattern_d = shl;
            if (shl[NUM_LEDS-1]) dir_d = DIR_DOWN;
          end else begin
            pattern_d = shr;
            if (shr[0]) dir_d = DIR_UP;
          end
        end
        MODE_COUNT: pattern_d = pattern_q + 1'b1;
        default:    pattern_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_OFF;
      pattern_q <= '0;
      dir_q     <= DIR_UP;
      tick_q    <= 1'b0;
      pwm_cnt_q <= '0;
      out_q     <= '0;
    end else begin
      mode_q    <= bus.mode;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      out_q     <= pattern_q & {NUM_LEDS{gate}};
    end
  end

  assign bus.out  = out_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;
  import led_pattern_pkg::*;

  localparam int NL = 4;
  localparam int TC = 4;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_pattern_gen_if #(.NUM_LEDS(NL), .PWM_WIDTH(PW)) bus ();

  led_pattern_gen #(
    .NUM_LEDS    (NL),
    .COUNT_WIDTH (8),
    .TICK_COUNT  (TC),
    .PWM_WIDTH   (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [NL-1:0] out;
    logic          tick;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: pattern is a function of (mode, steps taken since load).
  int m_mode  = 0;
  int m_steps = 0;
  int m_phase = 0;
  int m_pwm   = 0;

  function automatic int pattern_of(input int md, input int k);
    int pos;
    case (md)
      1: return 15;
      2: return (k % 2 == 1) ? 15 : 0;
      3: return 1 << (k % NL);
      4: begin
        pos = k % (2 * NL - 2);
        return 1 << ((pos < NL) ? pos : (2 * NL - 2 - pos));
      end
      5: return k % 16;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   br;
    if (rst) begin
      m_mode = 0; m_steps = 0; m_phase = 0; m_pwm = 0;
      e.out  = '0;
      e.tick = 1'b0;
    end else begin
      br     = int'(bus.brightness);
      e.out  = ((br == 15) || (m_pwm < br)) ? NL'(pattern_of(m_mode, m_steps)) : '0;
      e.tick = 1'b0;
      if (int'(bus.mode) != m_mode) begin
        m_mode  = int'(bus.mode);
        m_steps = 0;
        m_phase = 0;
      end else if (bus.enable) begin
        if (m_phase == TC - 1) begin
          m_phase = 0;
          m_steps = (m_steps + 1) % 48;
          e.tick  = 1'b1;
        end else begin
          m_phase = m_phase + 1;
        end
      end
      m_pwm = (m_pwm + 1) % 16;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.out !== e.out || bus.tick !== e.tick) begin
        errors++;
        $display("FAIL out_tick t=%0t: got out=%b tick=%b, expected out=%b tick=%b",
                 $time, bus.out, bus.tick, e.out, e.tick);
      end
    end
  end

  task automatic apply(input logic r, input int md, input logic en, input int br, input int n);
    rst            = r;
    bus.mode       = mode_e'(md[2:0]);
    bus.enable     = en;
    bus.brightness = br[PW-1:0];
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int md, en, br, n;
    md = 0;
    apply(1'b1, 0, 1'b0, 15, 2);
    apply(1'b0, 2, 1'b1, 15, 20);   // BLINK
    apply(1'b0, 3, 1'b1, 15, 20);   // CHASE
    apply(1'b0, 4, 1'b1, 15, 34);   // BOUNCE
    apply(1'b0, 5, 1'b1, 15, 70);   // COUNT
    apply(1'b0, 5, 1'b1, 15, 6);    // pause mid-interval
    apply(1'b0, 5, 1'b0, 15, 10);
    apply(1'b0, 5, 1'b1, 15, 12);
    apply(1'b0, 3, 1'b1, 15, 4);    // next edge is terminal count
    apply(1'b0, 2, 1'b1, 15, 8);    // mode change on that edge
    apply(1'b0, 1, 1'b1, 4, 40);    // PWM
    apply(1'b0, 1, 1'b1, 0, 20);
    apply(1'b0, 1, 1'b1, 15, 20);
    apply(1'b0, 4, 1'b1, 15, 18);   // BOUNCE moving down at 0100
    apply(1'b1, 4, 1'b1, 15, 1);
    apply(1'b0, 4, 1'b1, 15, 30);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) md = $urandom_range(0, 7);
      en = ($urandom_range(0, 4) != 0) ? 1 : 0;
      br = ($urandom_range(0, 2) == 0) ? 15 : $urandom_range(0, 15);
      n  = $urandom_range(1, 8);
      apply(($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0, md, en[0], br, n);
    end
    apply(1'b0, md, 1'b1, 15, 3);
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected at most 1", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
